systolic_mac_pe: RTL and testbench

- Parametrised systolic processing element for the fixed-point matrix-multiply array; next generation of the basic chained MAC cell.
- Forwards side (row) and top (column) operands with per-operand valid bits and accumulates exactly k_len aligned products.
- Exposes the finished dot product through a daisy-chained result drain path, so results leave the array by shifting.
- Adds configurable width, rounding, a wider accumulator, tile sequencing and misalignment error flagging.

---
 rtl/pe_pkg.sv | 35 +++
 rtl/fxp_mul_round.sv | 40 ++++
 rtl/systolic_mac_pe.sv | 164 ++++++++++++++++
 tb/tb_systolic_mac_pe.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared types and constants for the systolic MAC processing element.
// State encoding, default widths and the fixed-point constant helpers used for rounding and clamping.
package pe_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int FRAC_BITS_DEF = 23;
  localparam int ACC_W_DEF     = 48;
  localparam int K_W_DEF       = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ACCUM = ST_ACCUM,
    DONE  = ST_DONE,
    DRAIN = ST_DRAIN
  } pe_state_t;

  // Half an LSB of the rescaled product; zero when there are no fractional bits.
  function automatic logic signed [127:0] round_const(input int frac);
    return (frac > 0) ? (128'sd1 <<< (frac - 1)) : 128'sd0;
  endfunction

  function automatic logic signed [127:0] smax(input int w);
    return (128'sd1 <<< (w - 1)) - 128'sd1;
  endfunction

  function automatic logic signed [127:0] smin(input int w);
    return -(128'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/fxp_mul_round.sv
// Fixed-point multiply: full-width signed product, optional round-half-up, arithmetic rescale to ACC_W.
// Purely combinational (latency 0); no flow control.
module fxp_mul_round
  import pe_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int ROUND     = 1
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  p
);

  localparam int PW = 2 * DATA_W;
  localparam logic signed [PW-1:0] RC = PW'(round_const(FRAC_BITS));

  logic signed [PW-1:0] full;
  logic signed [PW-1:0] biased;
  logic signed [PW-1:0] shifted;

  // Sign-extended operands give the exact product modulo 2^PW, which is the full product.
  assign full    = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{b[DATA_W-1]}}, b};
  assign biased  = (ROUND != 0) ? full + RC : full;
  assign shifted = biased >>> FRAC_BITS;

  generate
    if (ACC_W > PW) begin : g_extend
      assign p = {{(ACC_W - PW){shifted[PW-1]}}, shifted};
    end else begin : g_narrow
      assign p = shifted[ACC_W-1:0];
      if (ACC_W < PW) begin : g_drop
        logic unused_hi;
        assign unused_hi = ^shifted[PW-1:ACC_W];
      end
    end
  endgenerate

endmodule

// File: rtl/systolic_mac_pe.sv
// Systolic MAC PE: forwards operands (latency 1), accumulates k_len aligned products, drains results by shifting.
// No backpressure; misaligned beats set err. Define PE_SATURATE_EN for saturating accumulate/narrowing with ovf.
module systolic_mac_pe
  import pe_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int K_W       = K_W_DEF,
  parameter int ROUND     = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic [K_W-1:0]           k_len,
  input  logic                     drain,
  input  logic signed [DATA_W-1:0] side_in,
  input  logic                     side_valid_in,
  input  logic signed [DATA_W-1:0] top_in,
  input  logic                     top_valid_in,
  input  logic [DATA_W-1:0]        res_in,
  input  logic                     res_valid_in,
  output logic [DATA_W-1:0]        side_out,
  output logic                     side_valid_out,
  output logic [DATA_W-1:0]        top_out,
  output logic                     top_valid_out,
  output logic [DATA_W-1:0]        res_out,
  output logic                     res_valid_out,
  output logic                     done,
  output logic                     busy,
  output logic                     err,
  output logic                     ovf
);

  pe_state_t               state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_next;
  logic [K_W-1:0]          count;
  logic [K_W-1:0]          klen_q;
  logic [DATA_W-1:0]       result_reg;
  logic [DATA_W-1:0]       res_narrow;
  logic                    clamp;
  logic                    both_valid;
  logic                    one_valid;
  logic                    fire;

  assign both_valid = side_valid_in & top_valid_in;
  assign one_valid  = side_valid_in ^ top_valid_in;
  assign fire       = (state == ACCUM) && both_valid;
  assign busy       = (state == ACCUM);

  fxp_mul_round #(
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS),
    .ACC_W    (ACC_W),
    .ROUND    (ROUND)
  ) u_mul (
    .a(side_in),
    .b(top_in),
    .p(prod)
  );

`ifdef PE_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(smax(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(smin(ACC_W));
  localparam logic signed [ACC_W-1:0] RES_MAX = ACC_W'(smax(DATA_W));
  localparam logic signed [ACC_W-1:0] RES_MIN = ACC_W'(smin(DATA_W));

  logic signed [ACC_W-1:0] acc_sum;
  logic                    add_clamp;

  always_comb begin
    acc_sum    = acc + prod;
    // Signed overflow: operands agree in sign but the sum does not.
    add_clamp  = (acc[ACC_W-1] == prod[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]);
    acc_next   = add_clamp ? (acc[ACC_W-1] ? ACC_MIN : ACC_MAX) : acc_sum;
    res_narrow = acc_next[DATA_W-1:0];
    clamp      = add_clamp;
    if (acc_next > RES_MAX) begin
      res_narrow = RES_MAX[DATA_W-1:0];
      clamp      = 1'b1;
    end else if (acc_next < RES_MIN) begin
      res_narrow = RES_MIN[DATA_W-1:0];
      clamp      = 1'b1;
    end
  end
`else
  assign acc_next   = acc + prod;
  assign res_narrow = acc_next[DATA_W-1:0];
  assign clamp      = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      acc            <= '0;
      count          <= '0;
      klen_q         <= '0;
      result_reg     <= '0;
      side_out       <= '0;
      side_valid_out <= 1'b0;
      top_out        <= '0;
      top_valid_out  <= 1'b0;
      res_out        <= '0;
      res_valid_out  <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      ovf            <= 1'b0;
    end else begin
      side_out       <= side_in;
      side_valid_out <= side_valid_in;
      top_out        <= top_in;
      top_valid_out  <= top_valid_in;
      done           <= 1'b0;
      res_valid_out  <= 1'b0;
      if (clear) begin
        acc    <= '0;
        count  <= '0;
        err    <= 1'b0;
        ovf    <= 1'b0;
        klen_q <= k_len;
        if (k_len == '0) begin
          state      <= DONE;
          result_reg <= '0;
          done       <= 1'b1;
        end else begin
          state <= ACCUM;
        end
      end else begin
        case (state)
          ACCUM: begin
            if (one_valid) err <= 1'b1;
            if (fire) begin
              acc   <= acc_next;
              count <= count + K_W'(1);
              ovf   <= ovf | clamp;
              if (count + K_W'(1) == klen_q) begin
                state      <= DONE;
                result_reg <= res_narrow;
                done       <= 1'b1;
              end
            end
          end
          DONE: begin
            if (both_valid) err <= 1'b1;
            if (drain) begin
              state         <= DRAIN;
              res_out       <= result_reg;
              res_valid_out <= 1'b1;
            end
          end
          DRAIN: begin
            if (both_valid) err <= 1'b1;
            res_out       <= res_in;
            res_valid_out <= res_valid_in;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Bench for systolic_mac_pe: directed vectors, drained results checked by per-instance scoreboards.
module tb_systolic_mac_pe;

  localparam int DW = 32;
  localparam int FB = 23;
  localparam int AW = 48;
  localparam int KW = 16;

`ifdef PE_SATURATE_EN
  localparam logic [DW-1:0] OVF_RES  = 32'h7FFF_FFFF;
  localparam logic          OVF_FLAG = 1'b1;
`else
  localparam logic [DW-1:0] OVF_RES  = 32'hFE00_0000;
  localparam logic          OVF_FLAG = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic          reset_n;
  logic          clear, drain;
  logic [KW-1:0] k_len;
  logic [DW-1:0] side_in, top_in;
  logic          side_valid_in, top_valid_in;
  logic [DW-1:0] zero_dat;
  logic          zero_vld;

  logic [DW-1:0] side_out, top_out, res_out;
  logic          side_valid_out, top_valid_out, res_valid_out, done, busy, err, ovf;

  logic [DW-1:0] t_side_out, t_top_out, t_res_out;
  logic          t_side_vld, t_top_vld, t_res_vld, t_done, t_busy, t_err, t_ovf;

  // Chain stimulus and wiring: PE0 -> PE1 -> PE2, c_res[3] is the array edge.
  logic          c_clear, c_drain, c_vld;
  logic [KW-1:0] c_klen;
  logic [DW-1:0] c_side [0:2];
  logic [DW-1:0] c_top;
  logic [DW-1:0] c_res [0:3];
  logic [3:0]    c_rv;
  logic [DW-1:0] c_so [0:2];
  logic [DW-1:0] c_to [0:2];
  logic [2:0]    c_sv, c_tv, c_done, c_busy, c_err, c_ovf;

  assign c_res[0] = '0;
  assign c_rv[0]  = 1'b0;

  systolic_mac_pe #(.DATA_W(DW), .FRAC_BITS(FB), .ACC_W(AW), .K_W(KW), .ROUND(1)) u_dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .k_len(k_len), .drain(drain),
    .side_in(side_in), .side_valid_in(side_valid_in), .top_in(top_in), .top_valid_in(top_valid_in),
    .res_in(zero_dat), .res_valid_in(zero_vld),
    .side_out(side_out), .side_valid_out(side_valid_out), .top_out(top_out), .top_valid_out(top_valid_out),
    .res_out(res_out), .res_valid_out(res_valid_out), .done(done), .busy(busy), .err(err), .ovf(ovf)
  );

  systolic_mac_pe #(.DATA_W(DW), .FRAC_BITS(FB), .ACC_W(AW), .K_W(KW), .ROUND(0)) u_trunc (
    .clk(clk), .reset_n(reset_n), .clear(clear), .k_len(k_len), .drain(drain),
    .side_in(side_in), .side_valid_in(side_valid_in), .top_in(top_in), .top_valid_in(top_valid_in),
    .res_in(zero_dat), .res_valid_in(zero_vld),
    .side_out(t_side_out), .side_valid_out(t_side_vld), .top_out(t_top_out), .top_valid_out(t_top_vld),
    .res_out(t_res_out), .res_valid_out(t_res_vld), .done(t_done), .busy(t_busy), .err(t_err), .ovf(t_ovf)
  );

  for (genvar g = 0; g < 3; g++) begin : g_chain
    systolic_mac_pe #(.DATA_W(DW), .FRAC_BITS(FB), .ACC_W(AW), .K_W(KW), .ROUND(1)) u_pe (
      .clk(clk), .reset_n(reset_n), .clear(c_clear), .k_len(c_klen), .drain(c_drain),
      .side_in(c_side[g]), .side_valid_in(c_vld), .top_in(c_top), .top_valid_in(c_vld),
      .res_in(c_res[g]), .res_valid_in(c_rv[g]),
      .side_out(c_so[g]), .side_valid_out(c_sv[g]), .top_out(c_to[g]), .top_valid_out(c_tv[g]),
      .res_out(c_res[g+1]), .res_valid_out(c_rv[g+1]), .done(c_done[g]), .busy(c_busy[g]),
      .err(c_err[g]), .ovf(c_ovf[g])
    );
  end

  logic [DW-1:0] q_main[$];
  logic [DW-1:0] q_tr[$];
  logic [DW-1:0] q_ch[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (res_valid_out === 1'b1) begin
      if (q_main.size() == 0) chk("main_res_unexpected", {32'h0, res_out}, 64'hDEAD_0000_0000_0000);
      else chk("main_res", {32'h0, res_out}, {32'h0, q_main.pop_front()});
    end
    if (t_res_vld === 1'b1) begin
      if (q_tr.size() == 0) chk("trunc_res_unexpected", {32'h0, t_res_out}, 64'hDEAD_0000_0000_0000);
      else chk("trunc_res", {32'h0, t_res_out}, {32'h0, q_tr.pop_front()});
    end
    if (c_rv[3] === 1'b1) begin
      if (q_ch.size() == 0) chk("chain_res_unexpected", {32'h0, c_res[3]}, 64'hDEAD_0000_0000_0000);
      else chk("chain_res", {32'h0, c_res[3]}, {32'h0, q_ch.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input logic [KW-1:0] k);
    clear = 1'b1;
    k_len = k;
    tick();
    clear = 1'b0;
  endtask

  task automatic fire(input logic [DW-1:0] s, input logic [DW-1:0] t);
    side_in = s;
    top_in  = t;
    side_valid_in = 1'b1;
    top_valid_in  = 1'b1;
    tick();
    side_valid_in = 1'b0;
    top_valid_in  = 1'b0;
  endtask

  task automatic do_drain(input logic [DW-1:0] exp_r, input logic [DW-1:0] exp_t);
    q_main.push_back(exp_r);
    q_tr.push_back(exp_t);
    drain = 1'b1;
    tick();
    drain = 1'b0;
    chk("drain_valid_on", {63'h0, res_valid_out}, 64'h1);
    tick();
    chk("drain_valid_off", {63'h0, res_valid_out}, 64'h0);
  endtask

  initial begin
    reset_n = 1'b0; clear = 1'b0; drain = 1'b0; k_len = '0;
    side_in = 32'h55; top_in = 32'h66; side_valid_in = 1'b1; top_valid_in = 1'b1;
    zero_dat = '0; zero_vld = 1'b0;
    c_clear = 1'b0; c_drain = 1'b0; c_vld = 1'b0; c_klen = '0; c_top = '0;
    c_side[0] = '0; c_side[1] = '0; c_side[2] = '0;
    tick(); tick();
    chk("rst_side_out", {32'h0, side_out}, 64'h0);
    chk("rst_side_vld", {63'h0, side_valid_out}, 64'h0);
    chk("rst_flags", {60'h0, res_valid_out, done, busy, err}, 64'h0);
    chk("rst_ovf", {63'h0, ovf}, 64'h0);
    side_valid_in = 1'b0; top_valid_in = 1'b0; side_in = '0; top_in = '0;
    reset_n = 1'b1;
    tick();

    // Drain request in IDLE must not produce anything.
    drain = 1'b1; tick(); drain = 1'b0;
    chk("idle_drain_ignored", {63'h0, res_valid_out}, 64'h0);

    // Q8.23 dot product: 1*2 + 1.5*1.5 + (-0.5)*1 = 3.75
    do_clear(16'd3);
    chk("accum_busy", {63'h0, busy}, 64'h1);
    fire(32'h0080_0000, 32'h0100_0000);
    chk("fwd_side", {32'h0, side_out}, 64'h0080_0000);
    chk("fwd_top_vld", {63'h0, top_valid_out}, 64'h1);
    chk("done_early1", {63'h0, done}, 64'h0);
    fire(32'h00C0_0000, 32'h00C0_0000);
    chk("done_early2", {63'h0, done}, 64'h0);
    fire(32'hFFC0_0000, 32'h0080_0000);
    chk("done_pulse", {63'h0, done}, 64'h1);
    chk("busy_off", {63'h0, busy}, 64'h0);
    tick();
    chk("done_one_cycle", {63'h0, done}, 64'h0);
    do_drain(32'h01E0_0000, 32'h01E0_0000);

    // Half-LSB product: rounds up to 1 LSB, truncates to 0.
    do_clear(16'd1);
    fire(32'h0000_0001, 32'h0040_0000);
    do_drain(32'h0000_0001, 32'h0000_0000);

    // 254.0 + 254.0 overflows Q8.23.
    do_clear(16'd2);
    fire(32'h3F80_0000, 32'h0100_0000);
    fire(32'h3F80_0000, 32'h0100_0000);
    chk("ovf_flag", {63'h0, ovf}, {63'h0, OVF_FLAG});
    do_drain(OVF_RES, OVF_RES);

    // k_len == 0 goes straight to DONE with a zero result.
    do_clear(16'd0);
    chk("klen0_done", {63'h0, done}, 64'h1);
    chk("klen0_ovf_cleared", {63'h0, ovf}, 64'h0);
    do_drain(32'h0, 32'h0);

    // Misaligned beat: err sticky, count unchanged, forwarding unaffected.
    do_clear(16'd2);
    chk("clear_err", {63'h0, err}, 64'h0);
    side_in = 32'h0000_1234; top_in = 32'h0000_ABCD; side_valid_in = 1'b1; top_valid_in = 1'b0;
    tick();
    side_valid_in = 1'b0;
    chk("misalign_err", {63'h0, err}, 64'h1);
    chk("misalign_fwd", {side_out, top_out}, {32'h0000_1234, 32'h0000_ABCD});
    chk("misalign_fwd_vld", {62'h0, side_valid_out, top_valid_out}, 64'h2);
    fire(32'h0080_0000, 32'h0080_0000);
    chk("misalign_no_count", {63'h0, done}, 64'h0);
    fire(32'h0080_0000, 32'h0080_0000);
    chk("misalign_done", {63'h0, done}, 64'h1);
    chk("err_sticky", {63'h0, err}, 64'h1);
    do_drain(32'h0100_0000, 32'h0100_0000);

    // Asynchronous reset in the middle of ACCUM.
    do_clear(16'd2);
    side_valid_in = 1'b1; tick(); side_valid_in = 1'b0;
    fire(32'h0080_0000, 32'h0080_0000);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_side_out", {32'h0, side_out}, 64'h0);
    chk("async_vld", {61'h0, side_valid_out, top_valid_out, res_valid_out}, 64'h0);
    chk("async_flags", {61'h0, busy, err, done}, 64'h0);
    tick();
    reset_n = 1'b1;
    side_in = 32'h0080_0000; top_in = 32'h0080_0000; side_valid_in = 1'b1; top_valid_in = 1'b1;
    tick(); tick();
    side_valid_in = 1'b0; top_valid_in = 1'b0;
    chk("post_rst_idle", {61'h0, busy, done, err}, 64'h0);
    do_clear(16'd1);
    fire(32'h0080_0000, 32'h0180_0000);
    chk("post_rst_done", {63'h0, done}, 64'h1);
    do_drain(32'h0180_0000, 32'h0180_0000);

    // Three-PE drain chain: results 1.0, 2.0, 3.0 leave as PE2, PE1, PE0.
    c_klen = 16'd1; c_clear = 1'b1; tick(); c_clear = 1'b0;
    c_side[0] = 32'h0080_0000; c_side[1] = 32'h0100_0000; c_side[2] = 32'h0180_0000;
    c_top = 32'h0080_0000; c_vld = 1'b1; tick(); c_vld = 1'b0;
    chk("chain_done", {61'h0, c_done}, 64'h7);
    q_ch.push_back(32'h0180_0000);
    q_ch.push_back(32'h0100_0000);
    q_ch.push_back(32'h0080_0000);
    c_drain = 1'b1; tick(); c_drain = 1'b0;
    tick(); tick(); tick();
    chk("chain_valid_off", {63'h0, c_rv[3]}, 64'h0);

    tick();
    chk("q_main_empty", 64'(q_main.size()), 64'h0);
    chk("q_trunc_empty", 64'(q_tr.size()), 64'h0);
    chk("q_chain_empty", 64'(q_ch.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
